axis_rr_packet_arbiter: RTL
===========================

Name: axis_rr_packet_arbiter

Overview:
Packet-level round-robin arbiter that shares the single 64-bit AXI-Stream slave input of axis_wrapper_top between NUM_SRC upstream sources. A grant is held from the first beat to the tlast of a packet, so packets never interleave. The output stage is registered and tags each packet with its source index. A beat-count watchdog truncates runaway packets at MAX_BEATS (one full frame: 10 datapoints x 13 packets = 130 words).

Parameters:
NUM_SRC, 2, number of requesting sources (2..4).
DATA_WIDTH, 64, tdata width in bits; tstrb width is DATA_WIDTH/8.
MAX_BEATS, 130, maximum beats per packet before forced truncation.
SRC_W, clog2(NUM_SRC) (min 1), width of the source index; derived, not overridable.

Ports:
aclk  in  1  clock; all logic on rising edge.
areset  in  1  synchronous, active-high reset.
s_axis_tvalid  in  NUM_SRC  per-source valid.
s_axis_tready  out  NUM_SRC  per-source ready.
s_axis_tdata  in  NUM_SRC*DATA_WIDTH  source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
s_axis_tstrb  in  NUM_SRC*DATA_WIDTH/8  per-source byte strobes, packed the same way.
s_axis_tlast  in  NUM_SRC  per-source end of packet.
m00_axis_tvalid  out  1  registered output valid.
m00_axis_tready  in  1  downstream ready.
m00_axis_tdata  out  DATA_WIDTH  registered data.
m00_axis_tstrb  out  DATA_WIDTH/8  registered strobes.
m00_axis_tlast  out  1  registered last; also asserted on truncation.
m00_axis_tdest  out  SRC_W  index of the granted source, constant across a packet.
busy  out  1  high while the FSM is not IDLE.
trunc_err  out  1  one-cycle pulse when a packet is truncated.

Behaviour:
- Reset values: all m00_* outputs 0, s_axis_tready all 0, busy 0, trunc_err 0, FSM IDLE, beat counter 0, last_grant = NUM_SRC-1 (source 0 wins first).
- Reset asserted mid-packet aborts everything. The output register is cleared with no tlast emitted; the partial packet is not completed.
- FSM states:
  - IDLE: all tready 0. If any tvalid is high, pick the winner by scanning from last_grant+1 modulo NUM_SRC. Register grant and tdest, then go to PASS. This costs one arbitration bubble cycle.
  - PASS: only the granted source sees tready = !m00_axis_tvalid || m00_axis_tready; all others see 0. An accepted beat loads the output register the next cycle (1-cycle latency) and increments the beat counter.
    - If an accepted beat has tlast=1: update last_grant to the granted index, clear the counter, go to IDLE.
    - If an accepted beat has tlast=0 and the counter is MAX_BEATS-1: force m00_axis_tlast=1 on that beat, pulse trunc_err, update last_grant, go to DRAIN.
  - DRAIN: the granted source's tready is 1 regardless of downstream. Its beats are discarded and the output register is not loaded. When a beat with tlast=1 is accepted, go to IDLE.
- Output register: holds its value while m00_axis_tvalid=1 and m00_axis_tready=0. It clears tvalid on a handshake unless a new beat loads in the same cycle, so back-to-back beats stream at full rate.
- The beat counter is wide enough for MAX_BEATS. It never wraps, because truncation fires first.
- A single-beat packet (tlast on beat 1) is legal.
- Simultaneous events:
  - A tlast beat followed by a new request costs exactly one IDLE cycle between packets.
  - Output handshake and new load in the same cycle: the register keeps tvalid=1 and takes the new data.
- A source dropping tvalid mid-packet keeps the grant (the packet is locked); no timeout applies.
- tdest only changes when the output register is empty or on the first beat of a new packet.

Test Plan:
1. Reset, then source 0 sends a 10-beat packet with data 0x1..0xA and m00_axis_tready=1. Expect m00 to carry 0x1..0xA one cycle after each accept, tlast on 0xA, tdest=0, busy falling the cycle after the last accept.
2. Both sources hold valid with 3-beat packets continuously. Expect grant order 0,1,0,1, tdest alternating, and exactly one idle cycle between packets.
3. Source 1 streams 10 beats while m00_axis_tready toggles 1,0,0,1 repeating. Expect no lost or duplicated beats, and m00 data stable whenever tready=0.
4. Source 0 sends 135 beats with tlast on beat 135. Expect m00 to emit 130 beats with tlast on beat 130 and one trunc_err pulse. Beats 131..135 are consumed with no m00 output. The next grant goes to source 1 if it is requesting.
5. Assert areset for one cycle during beat 5 of a packet. Expect all outputs 0 the next cycle, FSM IDLE, and source 0 winning the next arbitration.
6. Source 0 sends a single-beat packet 0xDEAD with tlast=1. Expect one m00 beat 0xDEAD with tlast=1 and tdest=0.

Source files
------------

// File: rtl/axis_rr_packet_arbiter.sv
// Packet-level round-robin arbiter merging NUM_SRC AXI-Stream sources into one
// registered master port tagged with the source index, with runaway-packet truncation.
module axis_rr_packet_arbiter #(
    parameter int NUM_SRC    = 2,
    parameter int DATA_WIDTH = 64,
    parameter int MAX_BEATS  = 130,
    localparam int SRC_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                           aclk,
    input  logic                           areset,
    input  logic [NUM_SRC-1:0]             s_axis_tvalid,
    output logic [NUM_SRC-1:0]             s_axis_tready,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]  s_axis_tdata,
    input  logic [NUM_SRC*DATA_WIDTH/8-1:0] s_axis_tstrb,
    input  logic [NUM_SRC-1:0]             s_axis_tlast,
    output logic                           m00_axis_tvalid,
    input  logic                           m00_axis_tready,
    output logic [DATA_WIDTH-1:0]          m00_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]        m00_axis_tstrb,
    output logic                           m00_axis_tlast,
    output logic [SRC_W-1:0]               m00_axis_tdest,
    output logic                           busy,
    output logic                           trunc_err
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int CNT_W  = $clog2(MAX_BEATS + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] PASS  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]            state;
    logic [SRC_W-1:0]      grant;
    logic [SRC_W-1:0]      last_grant;
    logic [SRC_W-1:0]      winner;
    logic [CNT_W-1:0]      beat_cnt;
    logic                  out_ready;
    logic                  accept;
    logic                  g_last;
    logic [DATA_WIDTH-1:0] g_data;
    logic [STRB_W-1:0]     g_strb;

    // Scan starts just after the previous winner so every source gets a turn.
    always_comb begin : arb
        int   idx;
        logic found;
        idx    = 0;
        found  = 1'b0;
        winner = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            idx = (int'(last_grant) + k) % NUM_SRC;
            if (!found && s_axis_tvalid[SRC_W'(idx)]) begin
                winner = SRC_W'(idx);
                found  = 1'b1;
            end
        end
    end

    assign out_ready = !m00_axis_tvalid || m00_axis_tready;
    assign g_data    = s_axis_tdata[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
    assign g_strb    = s_axis_tstrb[int'(grant)*STRB_W +: STRB_W];
    assign g_last    = s_axis_tlast[grant];

    // DRAIN swallows the tail of a truncated packet without waiting on downstream.
    always_comb begin
        s_axis_tready = '0;
        if (state == PASS) begin
            s_axis_tready[grant] = out_ready;
        end else if (state == DRAIN) begin
            s_axis_tready[grant] = 1'b1;
        end
    end

    assign accept = s_axis_tvalid[grant] && s_axis_tready[grant];
    assign busy   = (state != IDLE);

    always_ff @(posedge aclk) begin
        if (areset) begin
            state           <= IDLE;
            grant           <= '0;
            last_grant      <= SRC_W'(NUM_SRC - 1);
            beat_cnt        <= '0;
            trunc_err       <= 1'b0;
            m00_axis_tvalid <= 1'b0;
            m00_axis_tdata  <= '0;
            m00_axis_tstrb  <= '0;
            m00_axis_tlast  <= 1'b0;
            m00_axis_tdest  <= '0;
        end else begin
            trunc_err <= 1'b0;
            if (m00_axis_tvalid && m00_axis_tready) begin
                m00_axis_tvalid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (|s_axis_tvalid) begin
                        grant <= winner;
                        state <= PASS;
                    end
                end
                PASS: begin
                    if (accept) begin
                        m00_axis_tvalid <= 1'b1;
                        m00_axis_tdata  <= g_data;
                        m00_axis_tstrb  <= g_strb;
                        m00_axis_tdest  <= grant;
                        if (g_last) begin
                            m00_axis_tlast <= 1'b1;
                            last_grant     <= grant;
                            beat_cnt       <= '0;
                            state          <= IDLE;
                        end else if (beat_cnt == CNT_W'(MAX_BEATS - 1)) begin
                            m00_axis_tlast <= 1'b1;
                            trunc_err      <= 1'b1;
                            last_grant     <= grant;
                            beat_cnt       <= '0;
                            state          <= DRAIN;
                        end else begin
                            m00_axis_tlast <= 1'b0;
                            beat_cnt       <= beat_cnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (accept && g_last) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
